// File: rtl/ram_read_scheduler_pkg.sv
// Shared definitions for the read scheduler slice.
//   readram_req_t : one pending read (address + instruction tag)
//   *_DEFAULT     : default RAM address/data/tag widths
//   rr_next       : round-robin search from a pointer over a valid vector
package ooo_pkg;

  localparam int unsigned AW_DEFAULT   = 16;
  localparam int unsigned DW_DEFAULT   = 16;
  localparam int unsigned TAGW_DEFAULT = 8;
  localparam int unsigned MAX_REQ      = 8;

  typedef struct packed {
    logic [AW_DEFAULT-1:0]   addr;
    logic [TAGW_DEFAULT-1:0] tag;
  } readram_req_t;

  // Returns {found, index}: first set bit of valid_vector at or above pointer,
  // wrapping modulo num_req.
  function automatic logic [3:0] rr_next(input logic [2:0]         pointer,
                                         input logic [MAX_REQ-1:0] valid_vector,
                                         input int unsigned        num_req);
    logic [3:0]  result;
    int unsigned idx;
    result = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = (32'(pointer) + k) % num_req;
      if (k < num_req && !result[3] && valid_vector[idx[2:0]]) begin
        result = {1'b1, idx[2:0]};
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/ram_read_scheduler_rr_arbiter.sv
// Round-robin arbiter with a pointer register.
//   clk, rst : clock, synchronous active-high reset
//   valid    : per-requester request
//   enable   : grant permitted this cycle
//   grant    : one-hot grant (zero when nothing granted)
//   winner   : index of the round-robin winner
//   granted  : a grant is issued this cycle
module rr_arbiter
  import ooo_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [2:0]         winner,
  output logic               granted
);

  logic [2:0] pointer;
  logic [3:0] pick;

  always_comb begin
    pick    = rr_next(pointer, 8'(valid), NUM_REQ);
    granted = pick[3] & enable;
    winner  = pick[2:0];
    grant   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grant[i] = granted && (winner == 3'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pointer <= '0;
    end else if (granted) begin
      pointer <= (winner == 3'(NUM_REQ - 1)) ? '0 : winner + 3'd1;
    end
  end

endmodule

// File: rtl/ram_read_scheduler.sv
// Read scheduler for a dual-read/single-write block RAM.
// Tagged read requests are arbitrated round-robin into an in-order pending
// queue, issued up to two per cycle (port 1 = head, port 2 = head+1) and
// returned one cycle after issue with their tags. One write stream is
// registered onto the RAM write port; queued reads matching the address on
// the write port are held back.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/ready     : per-requester handshake, req_addr/req_tag flattened
//   wr_valid/ready      : write handshake with wr_addr/wr_data
//   flush               : drop queued and in-flight reads
//   ram_read_address*   : RAM read ports, ram_read_value* combinational data
//   ram_write_*         : RAM write port
//   resp_valid/tag/data : two response slots
//   busy                : queue, issue or response stage occupied
module ram_read_scheduler
  import ooo_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned QDEPTH  = 8,
  parameter int unsigned AW      = AW_DEFAULT,
  parameter int unsigned DW      = DW_DEFAULT,
  parameter int unsigned TAGW    = TAGW_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*AW-1:0]   req_addr,
  input  logic [NUM_REQ*TAGW-1:0] req_tag,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [AW-1:0]           wr_addr,
  input  logic [DW-1:0]           wr_data,
  input  logic                    flush,
  output logic [AW-1:0]           ram_read_address,
  input  logic [DW-1:0]           ram_read_value,
  output logic [AW-1:0]           ram_read_address2,
  input  logic [DW-1:0]           ram_read_value2,
  output logic                    ram_write_enabled,
  output logic [AW-1:0]           ram_write_address,
  output logic [DW-1:0]           ram_write_value,
  output logic [1:0]              resp_valid,
  output logic [2*TAGW-1:0]       resp_tag,
  output logic [2*DW-1:0]         resp_data,
  output logic                    busy
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  // Queue entries use the package struct, so AW/TAGW must stay at the
  // package defaults.
  readram_req_t queue [QDEPTH];
  readram_req_t entry;

  logic [PW-1:0] head, tail, head1;
  logic [CW-1:0] count, count_after_deq;
  logic          issue0, issue1, space, arb_enable, granted;
  logic [2:0]    winner;
  logic [1:0]    issue_valid;
  logic [TAGW-1:0] issue_tag0, issue_tag1;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (req_valid),
    .enable  (arb_enable),
    .grant   (req_ready),
    .winner  (winner),
    .granted (granted)
  );

  always_comb begin
    head1  = head + PW'(1);
    issue0 = (count != '0) &&
             !(ram_write_enabled && queue[head].addr == ram_write_address);
    // Port 2 only follows a port-1 issue, keeping issue strictly in order.
    issue1 = issue0 && (count >= CW'(2)) &&
             !(ram_write_enabled && queue[head1].addr == ram_write_address);
    count_after_deq = count - CW'(issue0) - CW'(issue1);
    space      = count_after_deq < CW'(QDEPTH);
    arb_enable = !rst && !flush && space;
    entry.addr = req_addr[32'(winner) * AW +: AW];
    entry.tag  = req_tag[32'(winner) * TAGW +: TAGW];
  end

  always_ff @(posedge clk) begin
    if (granted) begin
      queue[tail] <= entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      issue_valid       <= '0;
      issue_tag0        <= '0;
      issue_tag1        <= '0;
      ram_read_address  <= '0;
      ram_read_address2 <= '0;
      ram_write_enabled <= 1'b0;
      ram_write_address <= '0;
      ram_write_value   <= '0;
      resp_valid        <= '0;
      resp_tag          <= '0;
      resp_data         <= '0;
    end else begin
      ram_write_enabled <= wr_valid;
      if (wr_valid) begin
        ram_write_address <= wr_addr;
        ram_write_value   <= wr_data;
      end

      if (issue_valid[0]) begin
        resp_tag[TAGW-1:0] <= issue_tag0;
        resp_data[DW-1:0]  <= ram_read_value;
      end
      if (issue_valid[1]) begin
        resp_tag[2*TAGW-1:TAGW] <= issue_tag1;
        resp_data[2*DW-1:DW]    <= ram_read_value2;
      end

      if (flush) begin
        head        <= '0;
        tail        <= '0;
        count       <= '0;
        issue_valid <= '0;
        resp_valid  <= '0;
      end else begin
        resp_valid  <= issue_valid;
        issue_valid <= {issue1, issue0};
        if (issue0) begin
          ram_read_address <= queue[head].addr;
          issue_tag0       <= queue[head].tag;
        end
        if (issue1) begin
          ram_read_address2 <= queue[head1].addr;
          issue_tag1        <= queue[head1].tag;
        end
        head  <= head + PW'(issue0) + PW'(issue1);
        tail  <= tail + PW'(granted);
        count <= count_after_deq + CW'(granted);
      end
    end
  end

  assign wr_ready = !rst;
  assign busy     = (count != '0) | (|issue_valid) | (|resp_valid);

endmodule

// File: tb/tb_ram_read_scheduler.sv
module tb_ram_read_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned QDEPTH  = 8;
  localparam int unsigned AW      = 16;
  localparam int unsigned DW      = 16;
  localparam int unsigned TAGW    = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_REQ-1:0]      req_valid = '0;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*AW-1:0]   req_addr = '0;
  logic [NUM_REQ*TAGW-1:0] req_tag = '0;
  logic                    wr_valid = 1'b0;
  logic                    wr_ready;
  logic [AW-1:0]           wr_addr = '0;
  logic [DW-1:0]           wr_data = '0;
  logic                    flush = 1'b0;
  logic [AW-1:0]           ram_read_address, ram_read_address2;
  logic [DW-1:0]           ram_read_value, ram_read_value2;
  logic                    ram_write_enabled;
  logic [AW-1:0]           ram_write_address;
  logic [DW-1:0]           ram_write_value;
  logic [1:0]              resp_valid;
  logic [2*TAGW-1:0]       resp_tag;
  logic [2*DW-1:0]         resp_data;
  logic                    busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ram_read_scheduler #(
    .NUM_REQ(NUM_REQ), .QDEPTH(QDEPTH), .AW(AW), .DW(DW), .TAGW(TAGW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_tag(req_tag),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .flush(flush),
    .ram_read_address(ram_read_address), .ram_read_value(ram_read_value),
    .ram_read_address2(ram_read_address2), .ram_read_value2(ram_read_value2),
    .ram_write_enabled(ram_write_enabled),
    .ram_write_address(ram_write_address), .ram_write_value(ram_write_value),
    .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_data(resp_data),
    .busy(busy)
  );

  // RAM: combinational reads, write on the clock edge
  logic [DW-1:0] ram    [65536];
  logic [DW-1:0] shadow [65536];
  assign ram_read_value  = ram[ram_read_address];
  assign ram_read_value2 = ram[ram_read_address2];
  always @(posedge clk) if (ram_write_enabled) ram[ram_write_address] <= ram_write_value;

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 52) return 16'h1210;
    return 16'(a) ^ 16'hA5A5;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [TAGW-1:0] tag;
  } ent_t;

  ent_t            mq[$];
  int              mptr;
  bit              m_init = 0;
  bit              mw_en;
  logic [AW-1:0]   mw_a;
  logic [DW-1:0]   mw_d;
  bit              mi_v [2];
  logic [AW-1:0]   mi_a [2];
  logic [TAGW-1:0] mi_t [2];
  bit              mr_v [2];
  logic [TAGW-1:0] mr_t [2];
  logic [DW-1:0]   mr_d [2];
  int              d_n, d_win;
  bit              d_grant;

  task automatic decide();
    d_n = 0;
    if (mq.size() > 0 && !(mw_en && mq[0].addr == mw_a)) begin
      d_n = 1;
      if (mq.size() > 1 && !(mw_en && mq[1].addr == mw_a)) d_n = 2;
    end
    d_grant = 0;
    d_win   = 0;
    if (!rst && !flush && (mq.size() - d_n) < QDEPTH) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!d_grant && req_valid[(mptr + k) % NUM_REQ]) begin
          d_grant = 1;
          d_win   = (mptr + k) % NUM_REQ;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      if (mw_en) shadow[mw_a] = mw_d;
      mq.delete();
      mptr = 0; mw_en = 0; mw_a = '0; mw_d = '0;
      for (int k = 0; k < 2; k++) begin
        mi_v[k] = 0; mi_a[k] = '0; mi_t[k] = '0;
        mr_v[k] = 0; mr_t[k] = '0; mr_d[k] = '0;
      end
      m_init = 1;
    end else if (m_init) begin
      decide();
      for (int k = 0; k < 2; k++) begin
        if (mi_v[k]) begin
          mr_t[k] = mi_t[k];
          mr_d[k] = shadow[mi_a[k]];
        end
        mr_v[k] = flush ? 0 : mi_v[k];
      end
      if (flush) begin
        mq.delete();
        mi_v[0] = 0; mi_v[1] = 0;
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (k < d_n) begin
            ent_t e;
            e = mq.pop_front();
            mi_v[k] = 1; mi_a[k] = e.addr; mi_t[k] = e.tag;
          end else begin
            mi_v[k] = 0;
          end
        end
        if (d_grant) begin
          mq.push_back({req_addr[d_win*AW +: AW], req_tag[d_win*TAGW +: TAGW]});
          mptr = (d_win + 1) % NUM_REQ;
        end
      end
      if (mw_en) shadow[mw_a] = mw_d;
      mw_en = wr_valid;
      if (wr_valid) begin mw_a = wr_addr; mw_d = wr_data; end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_init) begin
      logic [NUM_REQ-1:0] exp_ready;
      decide();
      exp_ready = d_grant ? NUM_REQ'(1 << d_win) : '0;
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("wr_ready", 64'(wr_ready), 64'(!rst));
      chk("busy", 64'(busy), 64'(mq.size() != 0 || mi_v[0] || mi_v[1] || mr_v[0] || mr_v[1]));
      chk("resp_valid", 64'(resp_valid), 64'({mr_v[1], mr_v[0]}));
      if (mr_v[0]) begin
        chk("resp_tag0", 64'(resp_tag[TAGW-1:0]), 64'(mr_t[0]));
        chk("resp_data0", 64'(resp_data[DW-1:0]), 64'(mr_d[0]));
      end
      if (mr_v[1]) begin
        chk("resp_tag1", 64'(resp_tag[2*TAGW-1:TAGW]), 64'(mr_t[1]));
        chk("resp_data1", 64'(resp_data[2*DW-1:DW]), 64'(mr_d[1]));
      end
      chk("ram_we", 64'(ram_write_enabled), 64'(mw_en));
      if (mw_en) begin
        chk("ram_wa", 64'(ram_write_address), 64'(mw_a));
        chk("ram_wd", 64'(ram_write_value), 64'(mw_d));
      end
      if (mi_v[0]) chk("ram_ra1", 64'(ram_read_address), 64'(mi_a[0]));
      if (mi_v[1]) chk("ram_ra2", 64'(ram_read_address2), 64'(mi_a[1]));
    end
  end

  // response tag log and count
  logic [TAGW-1:0] rtags[$];
  int              rcount = 0;
  always @(negedge clk) begin
    if (resp_valid[0]) begin rtags.push_back(resp_tag[TAGW-1:0]); rcount++; end
    if (resp_valid[1]) begin rtags.push_back(resp_tag[2*TAGW-1:TAGW]); rcount++; end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [TAGW-1:0] t);
    req_addr[i*AW +: AW]     = a;
    req_tag[i*TAGW +: TAGW]  = t;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit hs;
    int rc0;
    for (int i = 0; i < 65536; i++) begin
      ram[i]    = init_val(i);
      shadow[i] = init_val(i);
    end

    // reset state
    step();
    step();
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_wr_ready", 64'(wr_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_tag", 64'(resp_tag), 64'(0));
    chk("rst_resp_data", 64'(resp_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ram_ra", 64'(ram_read_address), 64'(0));
    chk("rst_ram_we", 64'(ram_write_enabled), 64'(0));
    rst = 1'b0;
    step();

    // single read: handshake E0, issue E1, response after E2
    set_req(0, 16'd52, 8'd0);
    req_valid = 4'b0001;
    #1 chk("t1_ready", 64'(req_ready), 64'(4'b0001));
    step();
    req_valid = '0;
    step();
    chk("t1_no_resp_yet", 64'(resp_valid), 64'(0));
    step();
    chk("t1_resp_valid", 64'(resp_valid), 64'(2'b01));
    chk("t1_resp_tag", 64'(resp_tag[7:0]), 64'(8'd0));
    chk("t1_resp_data", 64'(resp_data[15:0]), 64'(16'h1210));
    step();
    chk("t1_busy_idle", 64'(busy), 64'(0));

    // dual issue: the write to 52 holds the head until 54 has joined it
    set_req(0, 16'd52, 8'd0);
    set_req(1, 16'd54, 8'd1);
    req_valid = 4'b0001;
    wr_valid = 1'b1; wr_addr = 16'd52; wr_data = 16'h1210;
    step();
    wr_valid = 1'b0;
    req_valid = 4'b0010;
    #1 chk("t2_ready1", 64'(req_ready), 64'(4'b0010));
    step();
    req_valid = '0;
    step();
    chk("t2_port1", 64'(ram_read_address), 64'(16'd52));
    chk("t2_port2", 64'(ram_read_address2), 64'(16'd54));
    step();
    chk("t2_both_valid", 64'(resp_valid), 64'(2'b11));
    chk("t2_tag0", 64'(resp_tag[7:0]), 64'(8'd0));
    chk("t2_tag1", 64'(resp_tag[15:8]), 64'(8'd1));
    chk("t2_data0", 64'(resp_data[15:0]), 64'(16'h1210));
    chk("t2_data1", 64'(resp_data[31:16]), 64'(16'hA593));
    step();

    // fairness
    do_reset();
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 4; i++) set_req(i, 16'(200 + i), 8'(16 * i + c));
      #1 chk("t3_rr_grant", 64'(req_ready), 64'(1 << (c % 4)));
      step();
    end
    req_valid = '0;
    repeat (6) step();

    // full queue: repeated writes to 300 pin the head entry
    rtags.delete();
    wr_valid = 1'b1; wr_addr = 16'd300; wr_data = 16'h7777;
    n = 0;
    set_req(0, 16'd300, 8'h40);
    req_valid = 4'b0001;
    for (int c = 0; c < 30 && n < 8; c++) begin
      #1 hs = req_ready[0];
      step();
      if (hs) begin
        n++;
        set_req(0, 16'(300 + n), 8'(8'h40 + n));
      end
    end
    chk("t4_filled", 64'(n), 64'(8));
    for (int c = 0; c < 3; c++) begin
      #1 chk("t4_full_ready", 64'(req_ready), 64'(0));
      step();
    end
    req_valid = '0;
    wr_valid = 1'b0;
    repeat (12) step();
    chk("t4_count", 64'(rtags.size()), 64'(8));
    for (int i = 0; i < rtags.size() && i < 8; i++)
      chk("t4_order", 64'(rtags[i]), 64'(8'h40 + i));

    // RAW hazard
    set_req(2, 16'd100, 8'h55);
    req_valid = 4'b0100;
    wr_valid = 1'b1; wr_addr = 16'd100; wr_data = 16'h0A35;
    #1 chk("t5_ready", 64'(req_ready), 64'(4'b0100));
    step();
    req_valid = '0;
    wr_valid = 1'b0;
    chk("t5_we", 64'(ram_write_enabled), 64'(1));
    chk("t5_wa", 64'(ram_write_address), 64'(16'd100));
    step();
    step();
    chk("t5_late_issue", 64'(ram_read_address), 64'(16'd100));
    chk("t5_no_early_resp", 64'(resp_valid), 64'(0));
    step();
    chk("t5_resp_valid", 64'(resp_valid), 64'(2'b01));
    chk("t5_tag", 64'(resp_tag[7:0]), 64'(8'h55));
    chk("t5_data", 64'(resp_data[15:0]), 64'(16'h0A35));
    repeat (3) step();

    // flush with three queued reads
    wr_valid = 1'b1; wr_addr = 16'd400; wr_data = 16'h1111;
    set_req(0, 16'd400, 8'h60);
    set_req(1, 16'd401, 8'h61);
    set_req(2, 16'd402, 8'h62);
    req_valid = 4'b0111;
    repeat (3) step();
    flush = 1'b1;
    #1 chk("t6_ready_flush", 64'(req_ready), 64'(0));
    chk("t6_busy_before", 64'(busy), 64'(1));
    step();
    flush = 1'b0;
    req_valid = '0;
    wr_valid = 1'b0;
    chk("t6_resp_after", 64'(resp_valid), 64'(0));
    chk("t6_busy_after", 64'(busy), 64'(0));
    rc0 = rcount;
    repeat (5) step();
    chk("t6_no_resp", 64'(rcount - rc0), 64'(0));

    // reset mid-burst
    for (int i = 0; i < 4; i++) set_req(i, 16'(500 + i), 8'(8'h70 + i));
    req_valid = 4'b1111;
    wr_valid = 1'b1; wr_addr = 16'd600; wr_data = 16'h2222;
    repeat (3) step();
    rst = 1'b1;
    step();
    step();
    chk("t7_req_ready", 64'(req_ready), 64'(0));
    chk("t7_wr_ready", 64'(wr_ready), 64'(0));
    chk("t7_resp_valid", 64'(resp_valid), 64'(0));
    chk("t7_resp_tag", 64'(resp_tag), 64'(0));
    chk("t7_resp_data", 64'(resp_data), 64'(0));
    chk("t7_busy", 64'(busy), 64'(0));
    chk("t7_we", 64'(ram_write_enabled), 64'(0));
    chk("t7_wa", 64'(ram_write_address), 64'(0));
    chk("t7_wd", 64'(ram_write_value), 64'(0));
    chk("t7_ra1", 64'(ram_read_address), 64'(0));
    chk("t7_ra2", 64'(ram_read_address2), 64'(0));
    req_valid = '0;
    wr_valid = 1'b0;
    rst = 1'b0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
